// File: rtl/bus_controller_pkg.sv
// Shared types for the external bus controller: FSM states, requester identity, word width.
package bus_controller_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    TRANSFER,
    RESPOND
  } bus_state_t;

  typedef enum logic {
    FETCH,
    DATA
  } requester_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Two-way round-robin grant, combinational (zero latency); grants only while enabled.
// grant[0] = fetch, grant[1] = data. On a tie the requester that lost last time wins.
module round_robin_arbiter
  import bus_controller_pkg::*;
(
  input  logic       enable,
  input  logic       fetch_request,
  input  logic       data_request,
  input  requester_t last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (fetch_request && data_request) begin
        grant = (last_grant == DATA) ? 2'b01 : 2'b10;
      end else if (fetch_request) begin
        grant = 2'b01;
      end else if (data_request) begin
        grant = 2'b10;
      end
    end
  end

endmodule

// File: rtl/bus_controller.sv
// Shares one narrow valid/ready bus between fetch and load/store; a 32-bit word takes
// NUM_BEATS+2 cycles with bus_ready high, and every beat is held stable while bus_ready is low.
module bus_controller
  import bus_controller_pkg::*;
#(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int BUS_ADDRESS_WIDTH = 8,
  parameter int BUS_DATA_WIDTH    = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         fetch_request,
  input  logic [ADDRESS_WIDTH-1:0]     fetch_address,
  output logic                         fetch_ready,
  output logic [WORD_WIDTH-1:0]        fetch_data,
  input  logic                         data_read_request,
  input  logic                         data_write_request,
  input  logic [ADDRESS_WIDTH-1:0]     data_address,
  input  logic [WORD_WIDTH-1:0]        data_write_data,
  output logic                         data_ready,
  output logic [WORD_WIDTH-1:0]        data_read_data,
  output logic                         bus_valid,
  output logic                         bus_write,
  output logic [BUS_ADDRESS_WIDTH-1:0] bus_address,
  output logic [BUS_DATA_WIDTH-1:0]    bus_write_data,
  input  logic                         bus_ready,
  input  logic [BUS_DATA_WIDTH-1:0]    bus_read_data
);

  localparam int NUM_BEATS  = WORD_WIDTH / BUS_DATA_WIDTH;
  localparam int BEAT_BYTES = BUS_DATA_WIDTH / 8;
  localparam int CW         = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  bus_state_t            state;
  requester_t            owner;
  requester_t            last_grant;
  logic [CW-1:0]         beat_count;
  logic [WORD_WIDTH-1:0] write_word;
  logic [WORD_WIDTH-1:0] read_word;
  logic [WORD_WIDTH-1:0] assembled;
  logic [1:0]            grant;
  logic                  handshake;
  logic                  last_beat;

  round_robin_arbiter u_arbiter (
    .enable        (state == IDLE),
    .fetch_request (fetch_request),
    .data_request  (data_read_request | data_write_request),
    .last_grant    (last_grant),
    .grant         (grant)
  );

  assign handshake      = bus_valid && bus_ready;
  assign last_beat      = (beat_count == CW'(NUM_BEATS - 1));
  assign bus_write_data = write_word[int'(beat_count)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];

  // Word as it will look once the beat currently on the bus is merged in.
  always_comb begin
    assembled = read_word;
    assembled[int'(beat_count)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = bus_read_data;
  end

  if (ADDRESS_WIDTH > BUS_ADDRESS_WIDTH) begin : g_high_address
    logic unused_high_address;
    assign unused_high_address = ^{fetch_address[ADDRESS_WIDTH-1:BUS_ADDRESS_WIDTH],
                                   data_address[ADDRESS_WIDTH-1:BUS_ADDRESS_WIDTH]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      owner          <= FETCH;
      last_grant     <= DATA;
      beat_count     <= '0;
      write_word     <= '0;
      read_word      <= '0;
      bus_valid      <= 1'b0;
      bus_write      <= 1'b0;
      bus_address    <= '0;
      fetch_ready    <= 1'b0;
      data_ready     <= 1'b0;
      fetch_data     <= '0;
      data_read_data <= '0;
    end else begin
      fetch_ready <= 1'b0;
      data_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            owner       <= grant[1] ? DATA : FETCH;
            last_grant  <= grant[1] ? DATA : FETCH;
            bus_address <= grant[1] ? data_address[BUS_ADDRESS_WIDTH-1:0]
                                    : fetch_address[BUS_ADDRESS_WIDTH-1:0];
            // A store wins over a load if both are (illegally) raised together.
            bus_write   <= grant[1] && data_write_request;
            write_word  <= data_write_data;
            beat_count  <= '0;
            bus_valid   <= 1'b1;
            state       <= TRANSFER;
          end
        end
        TRANSFER: begin
          if (handshake) begin
            read_word   <= assembled;
            beat_count  <= beat_count + CW'(1);
            bus_address <= bus_address + BUS_ADDRESS_WIDTH'(BEAT_BYTES);
            if (last_beat) begin
              bus_valid <= 1'b0;
              state     <= RESPOND;
              if (owner == FETCH) begin
                fetch_ready <= 1'b1;
                fetch_data  <= assembled;
              end else begin
                data_ready <= 1'b1;
                if (!bus_write) data_read_data <= assembled;
              end
            end
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_controller.sv
// Directed bench for bus_controller at default widths (8-bit beats, 8-bit bus address).
module tb_bus_controller;

  logic        clock;
  logic        reset;
  logic        fetch_request;
  logic [31:0] fetch_address;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        data_read_request;
  logic        data_write_request;
  logic [31:0] data_address;
  logic [31:0] data_write_data;
  logic        data_ready;
  logic [31:0] data_read_data;
  logic        bus_valid;
  logic        bus_write;
  logic [7:0]  bus_address;
  logic [7:0]  bus_write_data;
  logic        bus_ready;
  logic [7:0]  bus_read_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_fetch;
  logic [31:0] exp_load;

  bus_controller dut (
    .clock              (clock),
    .reset              (reset),
    .fetch_request      (fetch_request),
    .fetch_address      (fetch_address),
    .fetch_ready        (fetch_ready),
    .fetch_data         (fetch_data),
    .data_read_request  (data_read_request),
    .data_write_request (data_write_request),
    .data_address       (data_address),
    .data_write_data    (data_write_data),
    .data_ready         (data_ready),
    .data_read_data     (data_read_data),
    .bus_valid          (bus_valid),
    .bus_write          (bus_write),
    .bus_address        (bus_address),
    .bus_write_data     (bus_write_data),
    .bus_ready          (bus_ready),
    .bus_read_data      (bus_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called on a negedge whose following posedge samples the request in IDLE.
  // Returns on the negedge of the ready cycle.
  task automatic do_word(input logic [7:0] base, input logic wr, input logic is_fetch,
                         input logic [31:0] rword, input logic [31:0] wword,
                         input int stall_beat, input int stall_n);
    int c0;
    logic [7:0] a;
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      a = base + 8'(k);
      chk("beat_valid", {31'b0, bus_valid}, 32'd1);
      chk("beat_addr", {24'b0, bus_address}, {24'b0, a});
      chk("beat_write", {31'b0, bus_write}, {31'b0, wr});
      if (wr) chk("beat_wdata", {24'b0, bus_write_data}, {24'b0, wword[k*8 +: 8]});
      chk("beat_no_ready", {30'b0, fetch_ready, data_ready}, 32'd0);
      bus_read_data = wr ? 8'hA5 : rword[k*8 +: 8];
      if (k == stall_beat) begin
        bus_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clock);
          chk("stall_valid", {31'b0, bus_valid}, 32'd1);
          chk("stall_addr", {24'b0, bus_address}, {24'b0, a});
          if (wr) chk("stall_wdata", {24'b0, bus_write_data}, {24'b0, wword[k*8 +: 8]});
        end
        bus_ready = 1'b1;
      end
    end
    @(negedge clock);
    chk("resp_valid_low", {31'b0, bus_valid}, 32'd0);
    chk("latency", cyc - c0, 5 + stall_n);
    if (is_fetch) begin
      exp_fetch = rword;
      chk("fetch_ready_pulse", {31'b0, fetch_ready}, 32'd1);
      chk("data_ready_quiet", {31'b0, data_ready}, 32'd0);
    end else begin
      if (!wr) exp_load = rword;
      chk("data_ready_pulse", {31'b0, data_ready}, 32'd1);
      chk("fetch_ready_quiet", {31'b0, fetch_ready}, 32'd0);
    end
    chk("fetch_data", fetch_data, exp_fetch);
    chk("data_read_data", data_read_data, exp_load);
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    chk("idle_valid", {31'b0, bus_valid}, 32'd0);
    chk("idle_ready", {30'b0, fetch_ready, data_ready}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    fetch_request = 1'b0;
    fetch_address = '0;
    data_read_request = 1'b0;
    data_write_request = 1'b0;
    data_address = '0;
    data_write_data = '0;
    bus_ready = 1'b1;
    bus_read_data = '0;
    exp_fetch = '0;
    exp_load = '0;

    #2 reset = 1'b1;
    #1;
    chk("rst_bus_valid", {31'b0, bus_valid}, 32'd0);
    chk("rst_bus_write", {31'b0, bus_write}, 32'd0);
    chk("rst_bus_address", {24'b0, bus_address}, 32'd0);
    chk("rst_bus_wdata", {24'b0, bus_write_data}, 32'd0);
    chk("rst_readies", {30'b0, fetch_ready, data_ready}, 32'd0);
    chk("rst_fetch_data", fetch_data, 32'd0);
    chk("rst_load_data", data_read_data, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Fetch read at 0x10.
    fetch_request = 1'b1;
    fetch_address = 32'h10;
    do_word(8'h10, 1'b0, 1'b1, 32'h0000_0013, 32'h0, -1, 0);
    fetch_request = 1'b0;
    idle_cycle();

    // Store at 0x08.
    data_write_request = 1'b1;
    data_address = 32'h08;
    data_write_data = 32'hFE01_0113;
    do_word(8'h08, 1'b1, 1'b0, 32'h0, 32'hFE01_0113, -1, 0);
    data_write_request = 1'b0;
    idle_cycle();

    // Tie from reset: fetch, then data; repeat tie: fetch again.
    reset = 1'b1;
    exp_fetch = '0;
    exp_load = '0;
    @(negedge clock);
    reset = 1'b0;
    fetch_request = 1'b1;
    fetch_address = 32'h40;
    data_read_request = 1'b1;
    data_address = 32'h50;
    do_word(8'h40, 1'b0, 1'b1, 32'h0000_0093, 32'h0, -1, 0);
    fetch_request = 1'b0;
    idle_cycle();
    do_word(8'h50, 1'b0, 1'b0, 32'h1234_5678, 32'h0, -1, 0);
    data_read_request = 1'b0;
    idle_cycle();
    fetch_request = 1'b1;
    fetch_address = 32'h44;
    data_read_request = 1'b1;
    data_address = 32'h54;
    do_word(8'h44, 1'b0, 1'b1, 32'hAABB_CCDD, 32'h0, -1, 0);
    fetch_request = 1'b0;
    idle_cycle();
    do_word(8'h54, 1'b0, 1'b0, 32'h0BAD_F00D, 32'h0, -1, 0);
    data_read_request = 1'b0;
    idle_cycle();

    // Backpressure: three stall cycles on beat 2.
    fetch_request = 1'b1;
    fetch_address = 32'h20;
    do_word(8'h20, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0, 2, 3);
    fetch_request = 1'b0;
    idle_cycle();

    // Address wrap.
    data_read_request = 1'b1;
    data_address = 32'h0000_00FE;
    do_word(8'hFE, 1'b0, 1'b0, 32'h1122_3344, 32'h0, -1, 0);
    data_read_request = 1'b0;
    idle_cycle();

    // Reset during beat 2 of a store.
    data_write_request = 1'b1;
    data_address = 32'h60;
    data_write_data = 32'hCAFE_F00D;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("pre_rst_addr", {24'b0, bus_address}, 32'h60 + k);
      chk("pre_rst_wdata", {24'b0, bus_write_data}, {24'b0, data_write_data[k*8 +: 8]});
    end
    #2 reset = 1'b1;
    #1;
    chk("midrst_valid", {31'b0, bus_valid}, 32'd0);
    chk("midrst_data_ready", {31'b0, data_ready}, 32'd0);
    data_write_request = 1'b0;
    fetch_request = 1'b1;
    fetch_address = 32'h30;
    exp_fetch = '0;
    exp_load = '0;
    @(negedge clock);
    reset = 1'b0;
    chk("postrst_data_ready", {31'b0, data_ready}, 32'd0);
    do_word(8'h30, 1'b0, 1'b1, 32'h0102_0304, 32'h0, -1, 0);
    fetch_request = 1'b0;
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
